hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Parametrised hazard, forwarding and stall controller for the MIPS pipelined CPU; successor to the fixed 5-stage forwarding logic in the pipeline controller.
- Keeps an internal shadow of in-flight destination registers across FWD_STAGES stages.
- Selects per-operand forwarding sources and generates load-use and multi-cycle (MUL/DIV) stalls.
- Drives the per-stage enable/reset controls, including branch squash and debug single-step.

Parameters:
ADDR_W, 5, register address width
NUM_SRC, 2, source operands per instruction (operand 0 = rs, 1 = rt)
FWD_STAGES, 3, stages after ID that can forward (1 = EXE, 2 = MEM, 3 = WB)
LOAD_STAGE, 2, first stage index at which load data may be forwarded
MD_LAT, 4, MUL/DIV latency in cycles (at least 2)
SEL_W, clog2(FWD_STAGES+1), forwarding select width

Ports:
clk  in  1  main clock
rst  in  1  asynchronous, active-low reset
debug_en  in  1  freeze pipeline unless stepping
debug_step  in  1  step request; acts on its rising edge
id_valid  in  1  ID holds a real instruction
id_src_addr  in  NUM_SRC*ADDR_W  source register addresses
id_src_used  in  NUM_SRC  source i is read
id_dst_addr  in  ADDR_W  destination register
id_wen  in  1  ID instruction writes a register through the pipeline
id_is_load  in  1  load instruction
id_is_md  in  1  MUL/DIV issue; result written by the MD unit, not the pipeline
redirect  in  1  ID resolved a taken jump or branch
fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = stage k
stall  out  1  ID held this cycle
md_busy  out  1  MD unit occupied
md_done  out  1  one-cycle pulse; MD result write-back
md_dst  out  ADDR_W  MD destination register
if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables
if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  stage resets

Behaviour:
- Shadow entry e[k], k = 1..FWD_STAGES, holds {valid, wen, addr, is_load}.
- Advance rule (each clk edge when not frozen):
  - e[k] <= e[k-1] for k >= 2.
  - e[1] <= ID instruction if id_valid and not stall; otherwise a bubble (valid = 0).
- Forwarding, per operand i with id_src_used[i] = 1 and address != 0:
  - fwd_sel = smallest k with e[k].valid, e[k].wen and e[k].addr equal to the operand address.
  - If no stage matches, fwd_sel = 0. Operands not used, or reading r0, also get 0.
- Load-use stall: the matching entry has is_load and k < LOAD_STAGE.
  - fwd_sel still reports k.
- MD stalls: stall if md_busy and either
  - id_is_md (structural hazard), or
  - any used source, or id_dst_addr with id_wen, equals md_dst (RAW/WAW).
  - md_dst = 0 never stalls.
- MD counter:
  - On an MD issue that is not stalled: md_cnt <= MD_LAT, md_dst latched.
  - Otherwise md_cnt decrements while nonzero.
  - md_busy = (md_cnt != 0). md_done = (md_cnt == 1).
  - A new MD may issue in the cycle md_done = 1; that is not a structural stall.
- stall = load-use OR MD stall, gated by id_valid.
- Stage control priority, highest first:
  1. rst low: all *_rst = 1, all *_en = 1. Combinational and asynchronous. Shadow cleared, md_cnt = 0, md_dst = 0.
  2. Debug freeze (debug_en, no step edge): all *_en = 0, *_rst = 0. Shadow and md_cnt hold.
  3. stall: if_en = 0, id_en = 0, exe_rst = 1. A concurrent redirect is ignored and must be re-presented.
  4. redirect: id_rst = 1 (squashes the IF instruction).
  5. Default: all *_en = 1, *_rst = 0.
- Debug step edge:
  - Detected from a debug_step register; the register resets to 0.
  - A step edge advances exactly one cycle.
- Reset values: stall = 0, md_busy = 0, md_done = 0, md_dst = 0, fwd_sel = 0.
- Reset asserted mid-MD: the operation is abandoned and md_done is not produced.

Decomposition:
- Shared package holds the stage-index constants (FWD_NONE = 0, FWD_EXE = 1, FWD_MEM = 2, FWD_WB = 3), the shadow-entry field layout, and the stage-control bit order.
- One natural sub-module, hazard_md_scoreboard: MD counter, md_dst register, busy/done and MD stall logic.

Test Plan:
- add r3 <- r1,r2 then add r5 <- r3,r4: second instruction in ID gets fwd_sel[0] = 1, stall = 0. One cycle later with a bubble between: fwd_sel[0] = 2.
- lw r3 then add r5 <- r3,r4 back-to-back: stall = 1 for exactly 1 cycle, exe_rst = 1; next cycle fwd_sel[0] = 2, stall = 0.
- Dual match (r3 written in EXE and in WB): fwd_sel = 1 (youngest producer). Any source r0: fwd_sel = 0 always.
- mul r8 issued, MD_LAT = 4: md_busy high 4 cycles, md_done on the 4th. A dependent reader of r8 stalls 3 cycles. A second MD issued during the md_done cycle proceeds without stall.
- redirect with no stall: id_rst = 1 for 1 cycle. redirect coinciding with a load-use stall: id_rst = 0, stall = 1.
- debug_en = 1: shadow frozen for 10 cycles; one step pulse advances exactly 1 entry. Drop rst low mid-MD: md_busy = 0 immediately, all *_rst = 1, no md_done after release.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared constants for the hazard/forwarding controller: forwarding
// stage indices, shadow-entry bit layout and stage-control bit order.
package hazard_unit_pkg;

    // Forwarding select values: 0 = register file, k = pipeline stage k after ID.
    localparam int unsigned FWD_NONE = 0;
    localparam int unsigned FWD_EXE  = 1;
    localparam int unsigned FWD_MEM  = 2;
    localparam int unsigned FWD_WB   = 3;

    // Shadow entry layout, MSB to LSB: {valid, wen, addr[addr_w-1:0], is_load}.
    localparam int unsigned SH_LOAD_BIT = 0;
    localparam int unsigned SH_ADDR_LSB = 1;

    function automatic int unsigned sh_width(input int unsigned addr_w);
        return addr_w + 3;
    endfunction

    function automatic int unsigned sh_wen_bit(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic int unsigned sh_valid_bit(input int unsigned addr_w);
        return addr_w + 2;
    endfunction

    // Bit order of the internal stage enable/reset vectors.
    typedef enum logic [2:0] {
        STG_IF  = 3'd0,
        STG_ID  = 3'd1,
        STG_EXE = 3'd2,
        STG_MEM = 3'd3,
        STG_WB  = 3'd4
    } stage_t;

    localparam int unsigned NUM_STAGES = 5;

endpackage

// File: rtl/hazard_md_scoreboard.sv
// MUL/DIV scoreboard: latency counter, destination register, busy/done
// flags and the structural / RAW / WAW stall against the in-flight op.
module hazard_md_scoreboard
    import hazard_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MD_LAT  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      advance,
    input  logic                      issue,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic [ADDR_W-1:0]         dst_addr,
    input  logic                      wen,
    input  logic                      is_md,
    output logic                      busy,
    output logic                      done,
    output logic                      md_stall,
    output logic [ADDR_W-1:0]         dst
);

    localparam int unsigned CNT_W = $clog2(MD_LAT + 1);

    logic [CNT_W-1:0] cnt;
    logic             late;
    logic             raw_waw;

    assign busy = (cnt != '0);
    assign done = (cnt == CNT_W'(1));
    // In the write-back cycle the result is available, so nothing waits on it.
    assign late = (cnt > CNT_W'(1));

    // Load the latency on an accepted issue, otherwise count down while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            dst <= '0;
        end else if (issue) begin
            cnt <= CNT_W'(MD_LAT);
            dst <= dst_addr;
        end else if (advance && busy) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Stall ID on a second MD issue or on any register overlap with the MD target.
    always_comb begin
        raw_waw = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_used[i] && (src_addr[i*ADDR_W +: ADDR_W] == dst))
                raw_waw = 1'b1;
        end
        if (wen && (dst_addr == dst))
            raw_waw = 1'b1;
        if (dst == '0)
            raw_waw = 1'b0;
        md_stall = late && (is_md || raw_waw);
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard, forwarding and stall controller: tracks in-flight destinations
// in a shadow pipeline, picks forwarding sources, raises load-use and
// MUL/DIV stalls, and drives the per-stage enable/reset controls.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned MD_LAT     = 4,
    parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      debug_en,
    input  logic                      debug_step,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [ADDR_W-1:0]         id_dst_addr,
    input  logic                      id_wen,
    input  logic                      id_is_load,
    input  logic                      id_is_md,
    input  logic                      redirect,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic                      md_busy,
    output logic                      md_done,
    output logic [ADDR_W-1:0]         md_dst,
    output logic                      if_en,
    output logic                      id_en,
    output logic                      exe_en,
    output logic                      mem_en,
    output logic                      wb_en,
    output logic                      if_rst,
    output logic                      id_rst,
    output logic                      exe_rst,
    output logic                      mem_rst,
    output logic                      wb_rst
);

    localparam int unsigned ENT_W     = sh_width(ADDR_W);
    localparam int unsigned WEN_BIT   = sh_wen_bit(ADDR_W);
    localparam int unsigned VALID_BIT = sh_valid_bit(ADDR_W);

    logic                             step_q;
    logic                             step_edge;
    logic                             advance;
    logic [FWD_STAGES:1][ENT_W-1:0]   shadow;
    logic [ENT_W-1:0]                 new_ent;
    logic                             load_use;
    logic                             md_stall;
    logic                             md_issue;
    logic [ADDR_W-1:0]                src;
    logic                             hit;
    logic [NUM_STAGES-1:0]            stage_en;
    logic [NUM_STAGES-1:0]            stage_rst;

    // Pipeline moves when not in debug, or for exactly one cycle on a step edge.
    assign step_edge = debug_step && !step_q;
    assign advance   = !debug_en || step_edge;

    assign new_ent  = {1'b1, id_wen, id_dst_addr, id_is_load};
    assign stall    = id_valid && (load_use || md_stall);
    assign md_issue = id_valid && id_is_md && !stall && advance;

    // Remember the previous step level so a held step request acts only once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            step_q <= 1'b0;
        else
            step_q <= debug_step;
    end

    // Shift the destination shadow; a stalled or empty ID inserts a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
        end else if (advance) begin
            for (int unsigned k = 2; k <= FWD_STAGES; k++)
                shadow[k] <= shadow[k-1];
            shadow[1] <= (id_valid && !stall) ? new_ent : '0;
        end
    end

    // Youngest matching producer wins; a load too young to forward raises load-use.
    always_comb begin
        fwd_sel  = '0;
        load_use = 1'b0;
        src      = '0;
        hit      = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src = id_src_addr[i*ADDR_W +: ADDR_W];
            hit = 1'b0;
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_NONE);
            if (id_src_used[i] && (src != '0)) begin
                for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
                    if (!hit && shadow[k][VALID_BIT] && shadow[k][WEN_BIT] &&
                        (shadow[k][SH_ADDR_LSB +: ADDR_W] == src)) begin
                        hit = 1'b1;
                        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                        if (shadow[k][SH_LOAD_BIT] && (k < LOAD_STAGE))
                            load_use = 1'b1;
                    end
                end
            end
        end
    end

    hazard_md_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC),
        .MD_LAT  (MD_LAT)
    ) u_md (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .issue    (md_issue),
        .src_addr (id_src_addr),
        .src_used (id_src_used),
        .dst_addr (id_dst_addr),
        .wen      (id_wen),
        .is_md    (id_is_md),
        .busy     (md_busy),
        .done     (md_done),
        .md_stall (md_stall),
        .dst      (md_dst)
    );

    // Stage controls by priority: reset, debug freeze, stall, redirect, run.
    always_comb begin
        stage_en  = '1;
        stage_rst = '0;
        if (!rst) begin
            stage_rst = '1;
        end else if (!advance) begin
            stage_en = '0;
        end else if (stall) begin
            stage_en[STG_IF]   = 1'b0;
            stage_en[STG_ID]   = 1'b0;
            stage_rst[STG_EXE] = 1'b1;
        end else if (redirect) begin
            stage_rst[STG_ID] = 1'b1;
        end
    end

    assign if_en   = stage_en[STG_IF];
    assign id_en   = stage_en[STG_ID];
    assign exe_en  = stage_en[STG_EXE];
    assign mem_en  = stage_en[STG_MEM];
    assign wb_en   = stage_en[STG_WB];
    assign if_rst  = stage_rst[STG_IF];
    assign id_rst  = stage_rst[STG_ID];
    assign exe_rst = stage_rst[STG_EXE];
    assign mem_rst = stage_rst[STG_MEM];
    assign wb_rst  = stage_rst[STG_WB];

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver queues hand-computed
// expectations tagged with the cycle they apply to; a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_hazard_unit;

    typedef enum int { F_SEL0, F_SEL1, F_STALL, F_BUSY, F_DONE, F_DST, F_CTL } field_t;

    typedef struct {
        int     cyc;
        string  name;
        field_t f;
        int     val;
    } exp_t;

    // Control word {if,id,exe,mem,wb enables, if,id,exe,mem,wb resets}.
    localparam int CTL_RUN    = 'h3E0;
    localparam int CTL_RESET  = 'h3FF;
    localparam int CTL_FREEZE = 'h000;
    localparam int CTL_STALL  = 'h0E4;
    localparam int CTL_REDIR  = 'h3E8;

    logic       clk = 1'b0;
    logic       rst;
    logic       debug_en, debug_step;
    logic       id_valid;
    logic [9:0] id_src_addr;
    logic [1:0] id_src_used;
    logic [4:0] id_dst_addr;
    logic       id_wen, id_is_load, id_is_md, redirect;
    logic [3:0] fwd_sel;
    logic       stall, md_busy, md_done;
    logic [4:0] md_dst;
    logic       if_en, id_en, exe_en, mem_en, wb_en;
    logic       if_rst, id_rst, exe_rst, mem_rst, wb_rst;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   act;

    hazard_unit #(
        .ADDR_W     (5),
        .NUM_SRC    (2),
        .FWD_STAGES (3),
        .LOAD_STAGE (2),
        .MD_LAT     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .debug_en    (debug_en),
        .debug_step  (debug_step),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_used (id_src_used),
        .id_dst_addr (id_dst_addr),
        .id_wen      (id_wen),
        .id_is_load  (id_is_load),
        .id_is_md    (id_is_md),
        .redirect    (redirect),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .md_dst      (md_dst),
        .if_en       (if_en),
        .id_en       (id_en),
        .exe_en      (exe_en),
        .mem_en      (mem_en),
        .wb_en       (wb_en),
        .if_rst      (if_rst),
        .id_rst      (id_rst),
        .exe_rst     (exe_rst),
        .mem_rst     (mem_rst),
        .wb_rst      (wb_rst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(field_t f);
        case (f)
            F_SEL0:  return int'(fwd_sel[1:0]);
            F_SEL1:  return int'(fwd_sel[3:2]);
            F_STALL: return int'(stall);
            F_BUSY:  return int'(md_busy);
            F_DONE:  return int'(md_done);
            F_DST:   return int'(md_dst);
            F_CTL:   return int'({if_en, id_en, exe_en, mem_en, wb_en,
                                  if_rst, id_rst, exe_rst, mem_rst, wb_rst});
            default: return -1;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                act = actual(e.f);
                if (e.cyc != cyc)
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
                else if (act == e.val)
                    n_pass++;
                else
                    $display("FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", e.name, cyc, act, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic expect_val(input string name, input field_t f, input int val);
        exp_t x;
        x.cyc = cyc; x.name = name; x.f = f; x.val = val;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] used, input logic [4:0] dst,
                          input logic wen, input logic ld, input logic md);
        id_valid    = v;
        id_src_addr = {s1, s0};
        id_src_used = used;
        id_dst_addr = dst;
        id_wen      = wen;
        id_is_load  = ld;
        id_is_md    = md;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b0; debug_en = 1'b0; debug_step = 1'b0; redirect = 1'b0;
        idle();
        tick();
        // Reset with an MD instruction presented: nothing may issue.
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd8, 1'b0, 1'b0, 1'b1);
        expect_val("rst_ctl",   F_CTL,   CTL_RESET);
        expect_val("rst_stall", F_STALL, 0);
        expect_val("rst_busy",  F_BUSY,  0);
        expect_val("rst_done",  F_DONE,  0);
        expect_val("rst_dst",   F_DST,   0);
        expect_val("rst_sel0",  F_SEL0,  0);
        tick();
        rst = 1'b1;
        idle();
        expect_val("post_rst_busy", F_BUSY, 0);
        expect_val("post_rst_ctl",  F_CTL,  CTL_RUN);
        tick();

        // EXE forwarding, then MEM forwarding across a bubble.
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        expect_val("add1_sel0", F_SEL0, 0);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        expect_val("exe_fwd_sel0",  F_SEL0,  1);
        expect_val("exe_fwd_sel1",  F_SEL1,  0);
        expect_val("exe_fwd_stall", F_STALL, 0);
        expect_val("exe_fwd_ctl",   F_CTL,   CTL_RUN);
        tick();
        flush();
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        set_id(1'b1, 5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        expect_val("mem_fwd_sel0", F_SEL0, 2);
        tick();
        flush();

        // Load-use: one stall cycle, then MEM forwarding.
        set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        expect_val("lu_stall", F_STALL, 1);
        expect_val("lu_ctl",   F_CTL,   CTL_STALL);
        expect_val("lu_sel0",  F_SEL0,  1);
        tick();
        expect_val("lu_after_stall", F_STALL, 0);
        expect_val("lu_after_sel0",  F_SEL0,  2);
        expect_val("lu_after_ctl",   F_CTL,   CTL_RUN);
        tick();
        flush();

        // Dual producer, r0 source and unused operand.
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        expect_val("dual_sel0", F_SEL0, 1);
        expect_val("r0_sel1",   F_SEL1, 0);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 2'b10, 5'd6, 1'b1, 1'b0, 1'b0);
        expect_val("unused_sel0", F_SEL0, 0);
        tick();
        flush();

        // MUL r8, dependent reader stalls three cycles, released on md_done.
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd8, 1'b0, 1'b0, 1'b1);
        expect_val("mul_issue_stall", F_STALL, 0);
        expect_val("mul_issue_busy",  F_BUSY,  0);
        tick();
        set_id(1'b1, 5'd8, 5'd1, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_val("md_raw_stall", F_STALL, 1);
            expect_val("md_raw_busy",  F_BUSY,  1);
            expect_val("md_raw_done",  F_DONE,  0);
            expect_val("md_raw_dst",   F_DST,   8);
            tick();
        end
        expect_val("md_done_stall", F_STALL, 0);
        expect_val("md_done_busy",  F_BUSY,  1);
        expect_val("md_done_pulse", F_DONE,  1);
        tick();
        // DIV r10, structural stall, second MD issued in the done cycle.
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b0, 1'b0, 1'b1);
        expect_val("div_issue_busy", F_BUSY, 0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b0, 1'b0, 1'b1);
        expect_val("md_struct_stall", F_STALL, 1);
        expect_val("md_struct_ctl",   F_CTL,   CTL_STALL);
        tick();
        idle();
        tick();
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b0, 1'b0, 1'b1);
        expect_val("md_b2b_done",  F_DONE,  1);
        expect_val("md_b2b_stall", F_STALL, 0);
        expect_val("md_b2b_dst",   F_DST,   10);
        tick();
        idle();
        expect_val("md_b2b_busy", F_BUSY, 1);
        expect_val("md_b2b_new",  F_DST,  11);
        expect_val("md_b2b_nd",   F_DONE, 0);
        repeat (4) tick();
        expect_val("md_idle_busy", F_BUSY, 0);
        flush();

        // Redirect alone, then redirect under a load-use stall.
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
        redirect = 1'b1;
        expect_val("redir_ctl", F_CTL, CTL_REDIR);
        tick();
        redirect = 1'b0;
        idle();
        expect_val("redir_off_ctl", F_CTL, CTL_RUN);
        tick();
        set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        redirect = 1'b1;
        expect_val("redir_lu_stall", F_STALL, 1);
        expect_val("redir_lu_ctl",   F_CTL,   CTL_STALL);
        tick();
        redirect = 1'b0;
        flush();

        // Debug freeze for 10 cycles, then one step edge advances once.
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        debug_en = 1'b1;
        set_id(1'b1, 5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            expect_val("frz_sel0", F_SEL0, 1);
            expect_val("frz_ctl",  F_CTL,  CTL_FREEZE);
            tick();
        end
        debug_step = 1'b1;
        expect_val("step_ctl",  F_CTL,  CTL_RUN);
        expect_val("step_sel0", F_SEL0, 1);
        tick();
        set_id(1'b1, 5'd3, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            expect_val("held_step_ctl",  F_CTL,  CTL_FREEZE);
            expect_val("held_step_sel0", F_SEL0, 2);
            expect_val("held_step_sel1", F_SEL1, 1);
            tick();
        end
        debug_step = 1'b0;
        debug_en = 1'b0;
        flush();

        // Reset dropped mid-MD: operation abandoned, no md_done afterwards.
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd8, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        expect_val("pre_rst_busy", F_BUSY, 1);
        tick();
        rst = 1'b0;
        expect_val("mid_rst_busy", F_BUSY, 0);
        expect_val("mid_rst_ctl",  F_CTL,  CTL_RESET);
        expect_val("mid_rst_dst",  F_DST,  0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_val("post_rst_nodone", F_DONE, 0);
            expect_val("post_rst_idle",   F_BUSY, 0);
            tick();
        end

        idle();
        tick();
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d never sampled", e.name, e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
